stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every channel in bits.
REQ-002 Fixed channel count: 4 (channel index 0..3); not a parameter.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, named clk and rst.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 up_valid  input  1  upstream word present.
REQ-007 up_ready  output  1  block accepts upstream word this cycle.
REQ-008 up_sel  input  2  destination channel of upstream word.
REQ-009 up_data  input  WIDTH  upstream word.
REQ-010 down_valid  output  4  bit k: channel k holds a word.
REQ-011 down_ready  input  4  bit k: channel k consumer accepts.
REQ-012 down_data  output  4*WIDTH  slice [k*WIDTH +: WIDTH] = channel k word.
REQ-013 down_count  output  32  slice [k*8 +: 8] = channel k delivered-word count.

Function
REQ-014 Each channel SHALL have a one-entry holding register (valid bit + WIDTH data) and an 8-bit delivery counter.
REQ-015 up_ready SHALL be combinational: !rst && (!down_valid[up_sel] || down_ready[up_sel]).
REQ-016 Upstream transfer occurs when up_valid && up_ready; up_sel and up_data are ignored otherwise.
REQ-017 On upstream transfer, channel up_sel SHALL load up_data and set its down_valid on the next edge (latency 1 cycle).
REQ-018 Channel k drains when down_valid[k] && down_ready[k]; without a same-cycle load, down_valid[k] SHALL clear on the next edge.
REQ-019 Same-cycle drain and load of one channel SHALL replace the data and keep down_valid[k]=1 (one word per cycle sustained).
REQ-020 While down_valid[k] && !down_ready[k], down_data slice k SHALL remain stable; upstream words for channel k stall (up_ready=0).
REQ-021 A stall on one channel SHALL NOT affect other channels; an upstream word for a different non-blocked channel is accepted.
REQ-022 down_data slice k SHALL retain its last value after draining (no clearing).
REQ-023 Counter k SHALL increment by 1 on each channel-k drain, wrapping 255 -> 0.
REQ-024 down_valid/down_ready handshakes SHALL NOT depend combinationally on up_valid (no path up_valid -> down_valid).

Reset
REQ-025 With rst=1 at an edge: down_valid=4'b0, down_data=0, down_count=0 on the next cycle.
REQ-026 Reset SHALL override any same-cycle load, drain or count; held words are discarded without counting.
REQ-027 up_ready SHALL be 0 in every cycle rst=1.
REQ-028 Reset asserted mid-stream then released: first accepted word appears one cycle after acceptance, counters restart from 0.

Verification
REQ-029 Basic route: WIDTH=8, down_ready=4'hF, send 0xA5 sel=2 -> next cycle down_valid=4'b0100, slice2=0xA5; following cycle down_valid=0, down_count slice2=1.
REQ-030 Back-pressure: down_ready[1]=0, send 0x11 then 0x22 both sel=1 -> 0x11 held, up_ready=0 on 0x22 until down_ready[1]=1; then 0x22 loaded next cycle, count1=2 after both drain.
REQ-031 Independence: channel 0 stalled holding 0x33; send 0x44 sel=3 -> accepted immediately, slice3=0x44 next cycle, slice0 unchanged.
REQ-032 Throughput: down_ready=4'hF, 10 consecutive words sel=0 with up_valid=1 -> up_ready=1 every cycle, down_valid[0]=1 for 10 consecutive cycles, count0=10.
REQ-033 Wrap: 256 drains on channel 3 -> count3=0; 257th -> count3=1.
REQ-034 Reset mid-operation: channels 0 and 2 holding stalled words, pulse rst for one cycle -> down_valid=0, all counts 0, up_ready=0 during rst, normal acceptance the cycle after.

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux
// Routes one upstream valid/ready stream to four downstream channels.
// The destination of each upstream word is chosen by up_sel. Every channel
// has a one-entry holding register and an 8-bit count of delivered words.
//
// Ports
//   clk         clock; all state changes on the rising edge
//   rst         synchronous active-high reset
//   up_valid    upstream word present
//   up_ready    block accepts the upstream word this cycle
//   up_sel      destination channel (0..3) of the upstream word
//   up_data     upstream word, WIDTH bits
//   down_valid  bit k: channel k holds a word
//   down_ready  bit k: consumer of channel k accepts its word
//   down_data   slice [k*WIDTH +: WIDTH] is the word held by channel k
//   down_count  slice [k*8 +: 8] is the delivered-word count of channel k
module stream_demux #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               up_valid,
   output logic               up_ready,
   input  logic [1:0]         up_sel,
   input  logic [WIDTH-1:0]   up_data,
   output logic [3:0]         down_valid,
   input  logic [3:0]         down_ready,
   output logic [4*WIDTH-1:0] down_data,
   output logic [31:0]        down_count
);

   logic [3:0]       validReg;
   logic [WIDTH-1:0] dataReg  [4];
   logic [7:0]       countReg [4];
   logic [3:0]       loadChan;
   logic [3:0]       drainChan;

   // The selected channel can take a new word when it is empty, or when it is
   // being drained in this same cycle, so a channel sustains one word per
   // cycle. up_valid is deliberately absent here, which keeps any
   // combinational path from up_valid into the downstream handshake out of
   // the design. Nothing is accepted while reset is asserted.
   always_comb begin
      up_ready = !rst && (!validReg[up_sel] || down_ready[up_sel]);
   end

   // Per-channel load and drain strobes. A load only targets the channel
   // named by up_sel, and only when the upstream transfer really happens.
   always_comb begin
      loadChan  = '0;
      drainChan = '0;
      for (int k = 0; k < 4; k++) begin
         loadChan[k]  = up_valid && up_ready && (up_sel == 2'(k));
         drainChan[k] = validReg[k] && down_ready[k];
      end
   end

   // Holding registers and delivery counters. A load has priority over a
   // drain for the valid bit, so a same-cycle drain and load keeps the
   // channel full with the new word. Data is never cleared by a drain, so the
   // last delivered word stays visible. Counters wrap naturally at 8 bits.
   // Reset discards held words without counting them.
   always_ff @(posedge clk) begin
      if (rst) begin
         validReg <= '0;
         for (int k = 0; k < 4; k++) begin
            dataReg[k]  <= '0;
            countReg[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (loadChan[k]) begin
               validReg[k] <= 1'b1;
               dataReg[k]  <= up_data;
            end else if (drainChan[k]) begin
               validReg[k] <= 1'b0;
            end
            if (drainChan[k]) begin
               countReg[k] <= countReg[k] + 8'd1;
            end
         end
      end
   end

   // Flatten the per-channel state onto the packed output buses.
   always_comb begin
      down_valid = validReg;
      down_data  = '0;
      down_count = '0;
      for (int k = 0; k < 4; k++) begin
         down_data[k*WIDTH +: WIDTH] = dataReg[k];
         down_count[k*8 +: 8]        = countReg[k];
      end
   end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux
// Directed testbench for stream_demux with WIDTH=8. Inputs change 1 time
// unit after each rising edge; registered outputs and the combinational
// up_ready are sampled there as well, well away from the next edge.
module tb_stream_demux;

   logic        clk;
   logic        rst;
   logic        up_valid;
   logic        up_ready;
   logic [1:0]  up_sel;
   logic [7:0]  up_data;
   logic [3:0]  down_valid;
   logic [3:0]  down_ready;
   logic [31:0] down_data;
   logic [31:0] down_count;

   int compared;
   int mismatched;

   stream_demux #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_sel     (up_sel),
      .up_data    (up_data),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data),
      .down_count (down_count)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one set of inputs and let combinational outputs settle.
   task automatic applyStimulus(input logic v, input logic [1:0] sel,
                                input logic [7:0] data, input logic [3:0] rdy);
      up_valid   = v;
      up_sel     = sel;
      up_data    = data;
      down_ready = rdy;
      #1;
   endtask

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] dataOf(input int k);
      return down_data[k*8 +: 8];
   endfunction

   function automatic logic [7:0] countOf(input int k);
      return down_count[k*8 +: 8];
   endfunction

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      up_valid   = 1'b0;
      up_sel     = 2'd0;
      up_data    = 8'h00;
      down_ready = 4'h0;

      // Initial reset, with an upstream word offered that must be refused.
      $display("[TB] initial reset");
      applyStimulus(1'b1, 2'd1, 8'hEE, 4'hF);
      checkOutput("rst_up_ready", {31'd0, up_ready}, 32'd0);
      tick();
      tick();
      checkOutput("rst_up_ready_held", {31'd0, up_ready}, 32'd0);
      checkOutput("rst_down_valid", {28'd0, down_valid}, 32'd0);
      checkOutput("rst_down_data", down_data, 32'd0);
      checkOutput("rst_down_count", down_count, 32'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);

      // Basic route: 0xA5 to channel 2, drained by an always-ready consumer.
      $display("[TB] basic route");
      applyStimulus(1'b1, 2'd2, 8'hA5, 4'hF);
      checkOutput("route_up_ready", {31'd0, up_ready}, 32'd1);
      tick();
      applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
      checkOutput("route_valid", {28'd0, down_valid}, 32'h4);
      checkOutput("route_data2", {24'd0, dataOf(2)}, 32'hA5);
      checkOutput("route_count2_pre", {24'd0, countOf(2)}, 32'd0);
      tick();
      checkOutput("route_valid_after", {28'd0, down_valid}, 32'h0);
      checkOutput("route_count2", {24'd0, countOf(2)}, 32'd1);
      checkOutput("route_data2_kept", {24'd0, dataOf(2)}, 32'hA5);

      // Back-pressure on channel 1.
      $display("[TB] back-pressure");
      applyStimulus(1'b1, 2'd1, 8'h11, 4'b1101);
      checkOutput("bp_ready_first", {31'd0, up_ready}, 32'd1);
      tick();
      applyStimulus(1'b1, 2'd1, 8'h22, 4'b1101);
      checkOutput("bp_stall", {31'd0, up_ready}, 32'd0);
      tick();
      checkOutput("bp_stall_again", {31'd0, up_ready}, 32'd0);
      checkOutput("bp_held_data", {24'd0, dataOf(1)}, 32'h11);
      checkOutput("bp_held_valid", {28'd0, down_valid}, 32'h2);
      applyStimulus(1'b1, 2'd1, 8'h22, 4'hF);
      checkOutput("bp_release_ready", {31'd0, up_ready}, 32'd1);
      tick();
      applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
      checkOutput("bp_second_valid", {28'd0, down_valid}, 32'h2);
      checkOutput("bp_second_data", {24'd0, dataOf(1)}, 32'h22);
      checkOutput("bp_count_mid", {24'd0, countOf(1)}, 32'd1);
      tick();
      checkOutput("bp_count_final", {24'd0, countOf(1)}, 32'd2);
      checkOutput("bp_valid_final", {28'd0, down_valid}, 32'h0);

      // Independence: channel 0 stalled, channel 3 still flows.
      $display("[TB] independence");
      applyStimulus(1'b1, 2'd0, 8'h33, 4'b1110);
      tick();
      applyStimulus(1'b1, 2'd3, 8'h44, 4'b1110);
      checkOutput("ind_up_ready3", {31'd0, up_ready}, 32'd1);
      tick();
      applyStimulus(1'b0, 2'd0, 8'h00, 4'b1110);
      checkOutput("ind_valid", {28'd0, down_valid}, 32'h9);
      checkOutput("ind_data3", {24'd0, dataOf(3)}, 32'h44);
      checkOutput("ind_data0", {24'd0, dataOf(0)}, 32'h33);
      tick();
      checkOutput("ind_valid_after", {28'd0, down_valid}, 32'h1);
      checkOutput("ind_count3", {24'd0, countOf(3)}, 32'd1);
      checkOutput("ind_data0_stable", {24'd0, dataOf(0)}, 32'h33);
      applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
      tick();
      checkOutput("ind_count0", {24'd0, countOf(0)}, 32'd1);

      // Reset mid-operation with channels 0 and 2 holding stalled words.
      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 2'd0, 8'h55, 4'b1010);
      tick();
      applyStimulus(1'b1, 2'd2, 8'h66, 4'b1010);
      tick();
      applyStimulus(1'b0, 2'd0, 8'h00, 4'b1010);
      checkOutput("mid_valid_pre", {28'd0, down_valid}, 32'h5);
      rst = 1'b1;
      applyStimulus(1'b1, 2'd1, 8'h99, 4'hF);
      checkOutput("mid_rst_up_ready", {31'd0, up_ready}, 32'd0);
      tick();
      rst = 1'b0;
      applyStimulus(1'b1, 2'd1, 8'h77, 4'hF);
      checkOutput("mid_valid", {28'd0, down_valid}, 32'h0);
      checkOutput("mid_data", down_data, 32'd0);
      checkOutput("mid_count", down_count, 32'd0);
      checkOutput("mid_up_ready_after", {31'd0, up_ready}, 32'd1);
      tick();
      applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
      checkOutput("mid_first_valid", {28'd0, down_valid}, 32'h2);
      checkOutput("mid_first_data", {24'd0, dataOf(1)}, 32'h77);
      tick();
      checkOutput("mid_count1", {24'd0, countOf(1)}, 32'd1);

      // Throughput: ten back-to-back words to channel 0.
      $display("[TB] throughput");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 2'd0, 8'(8'h80 + i), 4'hF);
         checkOutput("thr_up_ready", {31'd0, up_ready}, 32'd1);
         tick();
         checkOutput("thr_valid0", {31'd0, down_valid[0]}, 32'd1);
         checkOutput("thr_data0", {24'd0, dataOf(0)}, 32'(8'h80 + i));
      end
      applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
      tick();
      checkOutput("thr_count0", {24'd0, countOf(0)}, 32'd10);
      checkOutput("thr_valid_end", {28'd0, down_valid}, 32'h0);

      // Counter wrap on channel 3.
      $display("[TB] counter wrap");
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 2'd3, 8'(i), 4'hF);
         tick();
      end
      checkOutput("wrap_count3_255", {24'd0, countOf(3)}, 32'd255);
      applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
      tick();
      checkOutput("wrap_count3_0", {24'd0, countOf(3)}, 32'd0);
      applyStimulus(1'b1, 2'd3, 8'hC3, 4'hF);
      tick();
      applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
      tick();
      checkOutput("wrap_count3_1", {24'd0, countOf(3)}, 32'd1);
      checkOutput("wrap_data3", {24'd0, dataOf(3)}, 32'hC3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
